// File: rtl/addsub_pkg.sv
// Shared types for the pipelined adder/subtractor.
// The result struct itself is declared inside the modules that carry it,
// because its sum width follows each instance's WIDTH parameter; the flag
// part is fixed-width and lives here.
package addsub_pkg;

    localparam int MAX_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } addsub_mode_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic zero;
    } addsub_flags_t;

endpackage

// File: rtl/addsub_stage.sv
// One pipeline slot of the add/sub datapath: a valid bit plus the registered
// result {sum, carry, ovf, zero}. The parent decides when the slot may take
// new contents (ready_i); the slot then loads its upstream neighbour, or
// empties if that neighbour has nothing valid, which collapses bubbles.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic              ready_i,
    input  logic [WIDTH-1:0]  sum_i,
    input  addsub_flags_t     flags_i,
    output logic              valid_o,
    output logic [WIDTH-1:0]  sum_o,
    output addsub_flags_t     flags_o
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        addsub_flags_t    flags;
    } result_t;

    logic    valid_q, valid_d;
    result_t data_q, data_d;

    // Next-state: take upstream contents when allowed, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d.sum   = sum_i;
                data_d.flags = flags_i;
            end
        end
    end

    // Slot register; reset empties the slot and zeroes the held result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = data_q.sum;
    assign flags_o = data_q.flags;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides and
// CARRY/OVF/ZERO flags. The arithmetic is combinational on the presented
// operands and is captured into stage 1; STAGES slots follow, so latency
// equals STAGES with no back-pressure and throughput is one op per cycle.
// Build option: define ADDSUB_SAT_EN to clamp overflowing results to the
// signed extreme (OVF still reports the overflow); otherwise SUM wraps.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             zero_o
);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("addsub_pipe: STAGES out of range 1..%0d", MAX_STAGES);
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_pipe: WIDTH must be at least 2");
    end

    logic             is_sub;
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] fe_sum;
    addsub_flags_t    fe_flags;

    // Index k is the input side of stage k; index k+1 is its output.
    logic [STAGES:0]  v_c;
    logic [STAGES:0]  rdy;
    logic [WIDTH-1:0] s_c [STAGES+1];
    addsub_flags_t    f_c [STAGES+1];

    // Front end: subtract is A + ~B + 1, so CARRY=1 means no borrow.
    always_comb begin
        is_sub         = (addsub_mode_e'(mode_i) == MODE_SUB);
        b_x            = b_i ^ {WIDTH{is_sub}};
        raw            = {1'b0, a_i} + {1'b0, b_x} + {{WIDTH{1'b0}}, is_sub};
        fe_sum         = raw[WIDTH-1:0];
        fe_flags.carry = raw[WIDTH];
        fe_flags.ovf   = (a_i[WIDTH-1] == b_x[WIDTH-1]) && (raw[WIDTH-1] != a_i[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        if (fe_flags.ovf) begin
            fe_sum = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        fe_flags.zero  = ~|fe_sum;
    end

    // Ready chain from the consumer backwards: a slot can take new data when
    // it is empty or its contents move on this cycle.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_c[k+1] || rdy[k+1];
        end
    end

    assign v_c[0] = in_valid_i;
    assign s_c[0] = fe_sum;
    assign f_c[0] = fe_flags;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .valid_i (v_c[k]),
            .ready_i (rdy[k]),
            .sum_i   (s_c[k]),
            .flags_i (f_c[k]),
            .valid_o (v_c[k+1]),
            .sum_o   (s_c[k+1]),
            .flags_o (f_c[k+1])
        );
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = v_c[STAGES];
    assign sum_o       = s_c[STAGES];
    assign carry_o     = f_c[STAGES].carry;
    assign ovf_o       = f_c[STAGES].ovf;
    assign zero_o      = f_c[STAGES].zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=32, STAGES=2).
module tb_addsub_pipe;

    localparam int W = 32;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry, ovf, zero;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;

    logic [W+2:0] exp_q[$];
    logic [W+2:0] got_q[$];

    addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .mode_i      (mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .carry_o     (carry),
        .ovf_o       (ovf),
        .zero_o      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, returns {sum, carry, ovf, zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        longint       sx, sy, r;
        logic [W-1:0] s;
        logic         c, o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!m) begin
            r      = sx + sy;
            {c, s} = {1'b0, x} + {1'b0, y};
        end else begin
            r = sx - sy;
            s = x - y;
            c = (x >= y);
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef ADDSUB_SAT_EN
        if (o) s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return {s, c, o, (s == '0)};
    endfunction

    // Transfer monitor: records accepted operands (as expected results) and emitted results.
    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, mode));
                n_in++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({sum, carry, ovf, zero});
                n_out++;
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if ({sum, carry, ovf, zero} !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {sum, carry, ovf, zero}); end
        @(posedge clk); #2 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed;
        logic [W-1:0] ta[4], tb_[4], ts[4];
        logic         tm[4], tc[4], to[4], tz[4];
        ta  = '{32'd15, 32'd10, 32'd0, 32'h7FFF_FFFF};
        tb_ = '{32'd7,  32'd10, 32'd1, 32'd1};
        tm  = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef ADDSUB_SAT_EN
        ts  = '{32'd22, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
`else
        ts  = '{32'd22, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
`endif
        tc  = '{1'b0, 1'b1, 1'b0, 1'b0};
        to  = '{1'b0, 1'b0, 1'b0, 1'b1};
        tz  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = ta[i]; b = tb_[i]; mode = tm[i]; in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b exp 0", i, out_valid); end
            @(posedge clk); @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got %b exp 1", i, out_valid); end
            checks++;
            if (sum !== ts[i]) begin errors++; $display("FAIL dir%0d_sum got %h exp %h", i, sum, ts[i]); end
            checks++;
            if ({carry, ovf, zero} !== {tc[i], to[i], tz[i]})
                begin errors++; $display("FAIL dir%0d_flags got %b exp %b", i, {carry, ovf, zero}, {tc[i], to[i], tz[i]}); end
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] oa[6], ob[6];
        logic         om[6];
        logic [W+2:0] prev_val;
        logic         hold_prev, saw_full, exp_rdy;
        int           base_in, base_out, idx, occ;
        for (int i = 0; i < 6; i++) begin
            oa[i] = W'($urandom_range(20, 10));
            ob[i] = W'($urandom_range(10, 0));
            om[i] = 1'($urandom_range(1, 0));
        end
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        base_in = n_in; base_out = n_out;
        hold_prev = 1'b0; saw_full = 1'b0; prev_val = '0;
        for (int cyc = 0; cyc < 40 && (n_out - base_out) < 6; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            idx = n_in - base_in;
            if (idx < 6) begin a = oa[idx]; b = ob[idx]; mode = om[idx]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            out_ready = !(cyc >= 2 && cyc < 5);
            @(negedge clk);
            occ = n_in - n_out;
            exp_rdy = (occ < S) || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b exp %b", cyc, in_ready, exp_rdy); end
            if (in_ready === 1'b0) saw_full = 1'b1;
            if (hold_prev) begin
                checks++;
                if ({sum, carry, ovf, zero} !== prev_val)
                    begin errors++; $display("FAIL bp_hold cyc%0d got %h exp %h", cyc, {sum, carry, ovf, zero}, prev_val); end
            end
            hold_prev = out_valid && !out_ready;
            prev_val  = {sum, carry, ovf, zero};
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_full got %b exp 1", saw_full); end
        checks++;
        if (got_q.size() != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== model(oa[i], ob[i], om[i]))
                begin errors++; $display("FAIL bp_result%0d got %h exp %h", i, got_q[i], model(oa[i], ob[i], om[i])); end
        end
    endtask

    task automatic test_random;
        int base_out, last_in, target;
        target = 30;
        @(posedge clk); #1;
        exp_q.delete(); got_q.delete();
        base_out = n_out; last_in = n_in - 1;
        for (int cyc = 0; cyc < 400 && (n_out - base_out) < target; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if ((n_in != last_in) || !in_valid) begin
                last_in = n_in;
                if (exp_q.size() < target) begin
                    a = $urandom; b = $urandom; mode = 1'($urandom_range(1, 0));
                    in_valid = ($urandom_range(3, 0) != 0);
                end else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3, 0) != 0);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (got_q.size() != exp_q.size() || got_q.size() == 0)
            begin errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_result%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midstream;
        logic [W-1:0] xa, xb;
        logic         xm;
        out_ready = 1'b1;
        @(posedge clk); #1 a = 32'd100; b = 32'd1; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 a = 32'd200; b = 32'd2; mode = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstm_inflight got %b exp 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_out_valid got %b exp 0", out_valid); end
        checks++;
        if ({sum, carry, ovf, zero} !== '0) begin errors++; $display("FAIL rstm_outputs got %h exp 0", {sum, carry, ovf, zero}); end
        @(posedge clk); #2 rst_n = 1'b1;
        exp_q.delete(); got_q.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_in_ready got %b exp 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_idle%0d got %b exp 0", i, out_valid); end
        end
        xa = $urandom; xb = $urandom; xm = 1'($urandom_range(1, 0));
        @(posedge clk); #1 a = xa; b = xb; mode = xm; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_early got %b exp 0", out_valid); end
        @(posedge clk); @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstm_latency got %b exp 1", out_valid); end
        checks++;
        if ({sum, carry, ovf, zero} !== model(xa, xb, xm))
            begin errors++; $display("FAIL rstm_result got %h exp %h", {sum, carry, ovf, zero}, model(xa, xb, xm)); end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
